// File: rtl/uart_fifo_ext_if.sv
// Bundle of request, data and status signals between the UART shift logic /
// register interface (master) and the UART data FIFO (slave).
interface uart_fifo_ext_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TO_WIDTH   = 16
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_err;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic                  flush;
    logic                  err_clr;
    logic [ADDR_WIDTH:0]   trig_level;
    logic [TO_WIDTH-1:0]   to_limit;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  thr_trig;
    logic                  overflow;
    logic                  underflow;
    logic                  err_in_fifo;
    logic                  timeout;

    modport master (
        output wr, wr_data, wr_err, rd, flush, err_clr, trig_level, to_limit,
        input  rd_data, rd_err, count, full, empty, thr_trig,
               overflow, underflow, err_in_fifo, timeout
    );

    modport slave (
        input  wr, wr_data, wr_err, rd, flush, err_clr, trig_level, to_limit,
        output rd_data, rd_err, count, full, empty, thr_trig,
               overflow, underflow, err_in_fifo, timeout
    );
endinterface

// File: rtl/uart_fifo_ext.sv
// UART data FIFO: first-word-fall-through read, accept-both when full,
// synchronous flush, sticky overflow/underflow, per-entry error tag and a
// 16550-style character timeout counter.
module uart_fifo_ext #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TO_WIDTH   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_fifo_ext_if.slave  bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0]   TO_ZERO  = {TO_WIDTH{1'b0}};
    localparam logic [TO_WIDTH-1:0]   TO_ONE   = {{(TO_WIDTH-1){1'b0}}, 1'b1};

    // Entry layout: {error tag, payload}. Contents are never reset.
    logic [DATA_WIDTH:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
    logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  err_in_fifo_q, err_in_fifo_d;
    logic                  timeout_q, timeout_d;

    logic [DATA_WIDTH:0]   head_s;
    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic                  push_err_s;
    logic                  pop_err_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;

    // Request qualification: a full FIFO still accepts a push when the head is popped.
    always_comb begin
        head_s     = mem_q[rd_ptr_q];
        push_acc_s = bus.wr && (!full_q || bus.rd);
        pop_acc_s  = bus.rd && !empty_q;
        push_err_s = push_acc_s && bus.wr_err;
        pop_err_s  = pop_acc_s && head_s[DATA_WIDTH];
        ovf_set_s  = !bus.flush && bus.wr && full_q && !bus.rd;
        unf_set_s  = !bus.flush && bus.rd && empty_q;
    end

    // Next-state computation; flush overrides any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (bus.flush) begin
            wr_ptr_d  = PTR_ZERO;
            rd_ptr_d  = PTR_ZERO;
            count_d   = CNT_ZERO;
            err_cnt_d = CNT_ZERO;
            to_cnt_d  = TO_ZERO;
            timeout_d = 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_acc_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            case ({push_err_s, pop_err_s})
                2'b10:   err_cnt_d = err_cnt_q + CNT_ONE;
                2'b01:   err_cnt_d = err_cnt_q - CNT_ONE;
                default: err_cnt_d = err_cnt_q;
            endcase
            // Any traffic or an empty FIFO restarts the idle timer.
            if (push_acc_s || pop_acc_s || (count_q == CNT_ZERO)) begin
                to_cnt_d  = TO_ZERO;
                timeout_d = 1'b0;
            end else begin
                // Saturate at the live limit so lowering it fires on the next edge.
                if (to_cnt_q < bus.to_limit) begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end else begin
                    to_cnt_d = bus.to_limit;
                end
                if ((bus.to_limit != TO_ZERO) && (to_cnt_d == bus.to_limit)) begin
                    timeout_d = 1'b1;
                end else begin
                    timeout_d = timeout_q;
                end
            end
        end
        full_d        = (count_d == CNT_FULL);
        empty_d       = (count_d == CNT_ZERO);
        err_in_fifo_d = (err_cnt_d != CNT_ZERO);
        // A set event wins over a clear in the same cycle.
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (bus.err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (unf_set_s) begin
            underflow_d = 1'b1;
        end else if (bus.err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            count_q       <= CNT_ZERO;
            err_cnt_q     <= CNT_ZERO;
            to_cnt_q      <= TO_ZERO;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            err_in_fifo_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            err_cnt_q     <= err_cnt_d;
            to_cnt_q      <= to_cnt_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            err_in_fifo_q <= err_in_fifo_d;
            timeout_q     <= timeout_d;
        end
    end

    // Storage write port; requests during reset or flush are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && push_acc_s) begin
            mem_q[wr_ptr_q] <= {bus.wr_err, bus.wr_data};
        end
    end

    assign bus.rd_data     = empty_q ? {DATA_WIDTH{1'b0}} : head_s[DATA_WIDTH-1:0];
    assign bus.rd_err      = empty_q ? 1'b0 : head_s[DATA_WIDTH];
    assign bus.thr_trig    = (count_q >= bus.trig_level);
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.err_in_fifo = err_in_fifo_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_uart_fifo_ext.sv
// Bench for uart_fifo_ext: directed boundary sequences followed by random
// traffic, checked by a queue-based reference model and a scoreboard monitor.
module tb_uart_fifo_ext;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TOW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_ext_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TO_WIDTH(TOW)) bus ();
    uart_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TO_WIDTH(TOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW:0] m_q[$];     // model contents {err, data}, head first
    logic [DW:0] exp_q[$];   // scoreboard: entries expected on the read port

    // Model state as seen after the most recent clock edge.
    int cur_count = 0;
    bit cur_ovf   = 1'b0;
    bit cur_unf   = 1'b0;
    bit cur_errin = 1'b0;
    bit cur_tmo   = 1'b0;
    int cur_to    = 0;
    bit mon_en    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle compare of status outputs and the head entry.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", int'(bus.count), cur_count);
            chk("full", int'(bus.full), int'(cur_count == DEPTH));
            chk("empty", int'(bus.empty), int'(cur_count == 0));
            chk("thr_trig", int'(bus.thr_trig), int'(cur_count >= int'(bus.trig_level)));
            chk("overflow", int'(bus.overflow), int'(cur_ovf));
            chk("underflow", int'(bus.underflow), int'(cur_unf));
            chk("err_in_fifo", int'(bus.err_in_fifo), int'(cur_errin));
            chk("timeout", int'(bus.timeout), int'(cur_tmo));
            if (cur_count == 0) begin
                chk("rd_data_empty", int'(bus.rd_data), 0);
                chk("rd_err_empty", int'(bus.rd_err), 0);
            end else if (!bus.flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: DUT presents data but none expected at %0t", $time);
                end else begin
                    chk("rd_data", int'(bus.rd_data), int'(exp_q[0][DW-1:0]));
                    chk("rd_err", int'(bus.rd_err), int'(exp_q[0][DW]));
                    if (bus.rd) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One clock cycle of stimulus; the model advances by the FIFO's rules.
    task automatic issue(input bit w, input logic [DW-1:0] d, input bit e,
                         input bit r, input bit f, input bit c);
        int cnt;
        int lim;
        bit push;
        bit pop;
        bit n_ovf;
        bit n_unf;
        bit n_tmo;
        int n_to;
        bus.wr      = w;
        bus.wr_data = d;
        bus.wr_err  = e;
        bus.rd      = r;
        bus.flush   = f;
        bus.err_clr = c;
        cnt   = m_q.size();
        lim   = int'(bus.to_limit);
        n_ovf = c ? 1'b0 : cur_ovf;
        n_unf = c ? 1'b0 : cur_unf;
        n_tmo = cur_tmo;
        n_to  = cur_to;
        if (f) begin
            m_q.delete();
            exp_q.delete();
            n_to  = 0;
            n_tmo = 1'b0;
        end else begin
            push = w && ((cnt < DEPTH) || r);
            pop  = r && (cnt > 0);
            if (w && (cnt == DEPTH) && !r) n_ovf = 1'b1;
            if (r && (cnt == 0)) n_unf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({e, d});
                exp_q.push_back({e, d});
            end
            if (push || pop || (cnt == 0)) begin
                n_to  = 0;
                n_tmo = 1'b0;
            end else begin
                n_to  = (cur_to < lim) ? cur_to + 1 : lim;
                n_tmo = cur_tmo || ((lim != 0) && (n_to == lim));
            end
        end
        @(posedge clk);
        #1;
        cur_count = m_q.size();
        cur_ovf   = n_ovf;
        cur_unf   = n_unf;
        cur_tmo   = n_tmo;
        cur_to    = n_to;
        cur_errin = 1'b0;
        foreach (m_q[i]) begin
            if (m_q[i][DW]) cur_errin = 1'b1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit e);
        issue(1'b1, d, e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        issue(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset for one edge; a write presented during reset must be dropped.
    task automatic do_reset(input bit w);
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        bus.wr      = w;
        bus.wr_data = 8'hEE;
        bus.wr_err  = 1'b1;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.wr    = 1'b0;
        m_q.delete();
        exp_q.delete();
        cur_count = 0;
        cur_ovf   = 1'b0;
        cur_unf   = 1'b0;
        cur_errin = 1'b0;
        cur_tmo   = 1'b0;
        cur_to    = 0;
        mon_en    = 1'b1;
    endtask

    initial begin
        int mode;
        bit w;
        bit r;
        bus.trig_level = 5'd8;
        bus.to_limit   = 16'd0;
        do_reset(1'b0);
        idle(1);

        // Fill and drain.
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++) pop();
        idle(1);

        // Overflow while full, sticky through idle, then err_clr.
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0);
        push(8'hAA, 1'b0);
        idle(5);
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < DEPTH - 3; i++) pop();
        // Simultaneous push/pop pairs across the pointer wrap.
        for (int i = 0; i < 40; i++) issue(1'b1, 8'(8'h40 + i), i[0], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pop();

        // Simultaneous read/write when full and when empty.
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i), 1'b0);
        issue(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop();
        issue(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        pop();
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Flush at count 7 with a concurrent write; overflow stays set.
        for (int i = 0; i < DEPTH; i++) push(8'(8'hC0 + i), i[1]);
        push(8'hAB, 1'b0);
        for (int i = 0; i < DEPTH - 7; i++) pop();
        issue(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Error tag tracking.
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b1);
        push(8'hC3, 1'b0);
        pop();
        pop();
        pop();

        // Character timeout.
        bus.to_limit = 16'd4;
        push(8'h5A, 1'b0);
        idle(6);
        pop();
        idle(5);
        bus.to_limit = 16'd0;
        push(8'h6B, 1'b0);
        idle(100);
        bus.to_limit = 16'd2;
        idle(2);
        pop();
        bus.to_limit = 16'd0;

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) push(8'(8'hD0 + i), 1'b1);
        do_reset(1'b1);
        idle(2);

        // Randomised traffic in write-heavy, read-heavy and balanced phases.
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 150) % 3;
            if ($urandom_range(0, 31) == 0) bus.trig_level = 5'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 63) == 0) bus.to_limit = 16'($urandom_range(0, 6));
            case (mode)
                0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
                1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
                default: begin w = ($urandom_range(0, 9) < 4); r = ($urandom_range(0, 9) < 4); end
            endcase
            issue(w, 8'($urandom), ($urandom_range(0, 3) == 0), r,
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(3);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_ext.md
# uart_fifo_ext

Parametrised UART data FIFO, successor to the current fixed UART FIFO. Sits between the UART receiver or transmitter shift logic and the register interface. Adds:
- first-word-fall-through read;
- accept-both on simultaneous read/write when full;
- synchronous flush;
- sticky, clearable overflow/underflow;
- a per-entry error tag with an "error in FIFO" flag;
- a 16550-style character timeout counter.

## Interface
- DATA_WIDTH, 8, payload width in bits
- DEPTH, 16, entries; power of two, ≥ 4
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)
- TO_WIDTH, 16, timeout counter width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr  in  1  push request
- wr_data  in  DATA_WIDTH  push data
- wr_err  in  1  error tag (parity/framing) stored with the pushed entry
- rd  in  1  pop request
- rd_data  out  DATA_WIDTH  head entry (FWFT); 0 when empty
- rd_err  out  1  error tag of head entry; 0 when empty
- flush  in  1  discard all contents
- err_clr  in  1  clear sticky overflow/underflow
- trig_level  in  ADDR_WIDTH+1  threshold for thr_trig
- to_limit  in  TO_WIDTH  idle cycles before timeout; 0 disables the timer
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- full / empty  out  1 each  count==DEPTH / count==0
- thr_trig  out  1  count ≥ trig_level
- overflow / underflow  out  1 each  sticky error flags
- err_in_fifo  out  1  at least one stored entry carries an error tag
- timeout  out  1  character timeout pending

## Operation
- **Storage.** DEPTH×(DATA_WIDTH+1) array, indexed by wr_ptr and rd_ptr. Pointers wrap modulo DEPTH. Array contents are not reset.
- **Push accepted** when wr && (!full || rd):
  - write {wr_err, wr_data} at wr_ptr;
  - increment wr_ptr.
- **Pop accepted** when rd && !empty: increment rd_ptr.
- **Count update:** count += push_acc − pop_acc.
- **Simultaneous wr && rd:**
  - full: both accepted, count stays DEPTH. The head is consumed and the new entry lands in the freed slot.
  - empty: push accepted, pop rejected; count becomes 1 and underflow sets.
  - otherwise: both accepted, count unchanged.
- **Sticky flags:**
  - overflow sets when wr && full && !rd.
  - underflow sets when rd && empty.
  - Both clear on err_clr. A set event in the same cycle as err_clr wins.
- **Error tracking.** err_cnt (ADDR_WIDTH+1 bits) counts stored tagged entries: +1 on an accepted push with wr_err, −1 on an accepted pop whose head tag is 1, net when both occur. err_in_fifo = (err_cnt != 0).
- **Flush.** Has priority over wr and rd in the same cycle. Zeroes pointers, count, err_cnt, the timeout counter and timeout. Sticky flags are untouched.
- **Timeout counter (to_cnt):**
  - cleared on any accepted push or pop, on flush, and whenever count==0;
  - otherwise increments each cycle, saturating at to_limit.
  - timeout sets at the edge where to_cnt becomes to_limit with to_limit≠0 and count>0.
  - timeout clears on an accepted push or pop, on flush, or when count reaches 0.
- **Precedence:** rst_n low > flush > push/pop.

## Timing
- **Reset** (rst_n sampled low at an edge), values after that edge:
  - count=0, empty=1, full=0, thr_trig=(trig_level==0);
  - overflow=0, underflow=0, err_in_fifo=0, timeout=0;
  - rd_data=0, rd_err=0.
- **Reset mid-operation** discards all contents and drops any request in that cycle.
- **Registered outputs:** count, full, empty, overflow, underflow, err_in_fifo and timeout are registered, updated at the edge that accepts the event.
- **Combinational outputs:** rd_data and rd_err (from rd_ptr and empty), and thr_trig (from registered count and live trig_level).
- **Push to read latency:** data pushed into an empty FIFO at edge N appears on rd_data after edge N (one cycle).
- **Pop handshake:** the consumer samples rd_data in the same cycle it asserts rd. The next entry is presented after that edge.
- **Full-to-not-full:** a pop alone makes full deassert after the edge. A write in the cycle after a full-state pop is accepted.
- **Timeout latency:** after the last push or pop at edge E, with no further activity and count>0, timeout rises after edge E+to_limit.
- **to_limit change:** takes effect immediately. Lowering it below the current to_cnt sets timeout at the next edge.

## Test plan
- **Reset, fill and drain.** Reset, then 16 pushes 0x00..0x0F (DEPTH=16) → full=1 after the 16th, count=16. Then 16 pops → data 0x00..0x0F in order, empty=1, rd_data=0.
- **Overflow and wrap.**
  - Push 0xAA while full (rd=0) → data dropped, overflow=1. It stays 1 through 5 idle cycles and clears the cycle after err_clr.
  - Then 40 push/pop pairs across the wrap → data matches.
- **Simultaneous read/write at the boundaries.**
  - Full, wr+rd with 0x55 → count stays 16, popped data is the old head, 0x55 is read last.
  - Empty, wr+rd with 0x33 → count=1, underflow=1, rd_data=0x33 next cycle.
- **Flush.** Flush with count=7 and wr=1 in the same cycle → count=0, empty=1, err_in_fifo=0, overflow unchanged, the concurrent write is lost.
- **Error tag.** Push A(err=0), B(err=1), C(err=0) → err_in_fifo=1. Pop A → still 1. Pop B (rd_err=1 while head) → err_in_fifo=0.
- **Timeout.**
  - to_limit=4, one push at edge E → timeout=1 after edge E+4.
  - A pop clears it; count=0 keeps it low.
  - to_limit=0 → never asserts in 100 cycles.
